// File: rtl/ysyx_22050243_lsu_pkg.sv
// ysyx_22050243_lsu_pkg: LSU state encoding, RV64 load/store funct3 codes and access-size helper
package ysyx_22050243_lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  function automatic logic [3:0] size_of(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction
endpackage

// File: rtl/ysyx_22050243_lsu_if.sv
// ysyx_22050243_lsu_if: valid/ready data-memory bus between the LSU (master) and memory (slave)
interface ysyx_22050243_lsu_if #(parameter int ADDR_W = 64, parameter int XLEN = 64);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [7:0]        req_wmask;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  modport master(output req_valid, req_wen, req_addr, req_wdata, req_wmask, input req_ready, resp_valid, resp_rdata);
  modport slave(input req_valid, req_wen, req_addr, req_wdata, req_wmask, output req_ready, resp_valid, resp_rdata);
endinterface

// File: rtl/ysyx_22050243_lsu_align.sv
// ysyx_22050243_lsu_align: byte-lane mask, store data shift and load shift/extend
module ysyx_22050243_lsu_align
  import ysyx_22050243_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      off_i,
  input  logic            wen_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [7:0]      wmask_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);
  logic [XLEN-1:0] sh;
  logic [7:0]      base;
  // reserved store sizes write no bytes; doubles always strobe every lane
  always_comb begin
    base    = funct3_i[1:0] == 2'd0 ? 8'h01 : funct3_i[1:0] == 2'd1 ? 8'h03 : 8'h0F;
    wmask_o = (wen_i && funct3_i[2]) ? 8'h00 : funct3_i[1:0] == 2'd3 ? 8'hFF : base << off_i;
    wdata_o = wdata_i << {off_i, 3'b000};
    sh      = rdata_i >> {off_i, 3'b000};
    rdata_o = '0;
    case (funct3_i)
      F3_B:    rdata_o = {{(XLEN-8){sh[7]}}, sh[7:0]};
      F3_H:    rdata_o = {{(XLEN-16){sh[15]}}, sh[15:0]};
      F3_W:    rdata_o = {{(XLEN-32){sh[31]}}, sh[31:0]};
      F3_D:    rdata_o = sh;
      F3_BU:   rdata_o = {{(XLEN-8){1'b0}}, sh[7:0]};
      F3_HU:   rdata_o = {{(XLEN-16){1'b0}}, sh[15:0]};
      F3_WU:   rdata_o = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: rdata_o = '0;
    endcase
  end
endmodule

// File: rtl/ysyx_22050243_lsu.sv
// ysyx_22050243_lsu: multi-cycle load/store unit; YSYX_22050243_LSU_MISALIGN_CHK_EN enables misaligned-access trapping
module ysyx_22050243_lsu
  import ysyx_22050243_lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int XLEN   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_r_i,
  input  logic                 mem_w_i,
  input  logic [2:0]           funct3_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [XLEN-1:0]      wdata_i,
  output logic                 stall_o,
  output logic                 done_o,
  output logic [XLEN-1:0]      rdata_o,
  output logic                 misalign_o,
  ysyx_22050243_lsu_if.master  bus
);
  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic [2:0]        f3_q;
  logic              wen_q;
  logic              req_valid_q;
  logic              done_q;
  logic              misalign_q;
  logic              mis;
  logic [7:0]        wmask;
  logic [XLEN-1:0]   wdata_sh;
  logic [XLEN-1:0]   rdata_ext;
`ifdef YSYX_22050243_LSU_MISALIGN_CHK_EN
  logic [2:0] lo;
  assign lo  = 3'(size_of(funct3_i) - 4'd1);
  assign mis = |(addr_i[2:0] & lo);
`else
  assign mis = 1'b0;
`endif
  ysyx_22050243_lsu_align #(.XLEN(XLEN)) u_align (
    .funct3_i(f3_q),
    .off_i   (addr_q[2:0]),
    .wen_i   (wen_q),
    .wdata_i (wdata_q),
    .rdata_i (bus.resp_rdata),
    .wmask_o (wmask),
    .wdata_o (wdata_sh),
    .rdata_o (rdata_ext)
  );
  assign bus.req_valid = req_valid_q;
  assign bus.req_wen   = req_valid_q & wen_q;
  assign bus.req_addr  = req_valid_q ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign bus.req_wdata = req_valid_q ? wdata_sh : '0;
  assign bus.req_wmask = req_valid_q ? wmask : 8'h00;
  assign stall_o       = (mem_r_i | mem_w_i) & (state_q != DONE);
  assign done_o        = done_q;
  assign rdata_o       = rdata_q;
  assign misalign_o    = misalign_q;
  // access sequencer: latch operands, hold the request until accepted, wait for the response, pulse done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      f3_q        <= '0;
      wen_q       <= 1'b0;
      req_valid_q <= 1'b0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (mem_r_i | mem_w_i) begin
          addr_q     <= addr_i;
          wdata_q    <= wdata_i;
          f3_q       <= funct3_i;
          wen_q      <= ~mem_r_i;
          misalign_q <= mis;
          if (mis) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            rdata_q <= '0;
          end else begin
            state_q     <= REQ;
            req_valid_q <= 1'b1;
          end
        end
        REQ: if (bus.req_ready) begin
          req_valid_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: if (bus.resp_valid) begin
          rdata_q <= wen_q ? '0 : rdata_ext;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22050243_lsu.sv
// tb_ysyx_22050243_lsu: scoreboard bench with a byte-level reference model and a randomized bus responder
module tb_ysyx_22050243_lsu;
  import ysyx_22050243_lsu_pkg::*;
  typedef struct { logic [63:0] addr; logic [63:0] wdata; logic [7:0] mask; logic wen; } req_t;
  typedef struct { logic [63:0] rdata; logic mis; int issue; int lat; } done_t;
  typedef struct { logic [63:0] data; int rdy; int rsp; } bus_t;
  logic        clk = 0;
  logic        rst_n;
  logic        mem_r, mem_w;
  logic [2:0]  funct3;
  logic [63:0] addr, wdata;
  logic        stall, done, misalign;
  logic [63:0] rdata;
  logic        force_resp;
  int          n_pass = 0, n_chk = 0, cyc = 0, ph = 0, cnt = 0, n_done = 0, n_req = 0;
  int          last_lat;
  logic [63:0] last_rdata, last_addr, last_wdata;
  logic [7:0]  last_wmask;
  logic        last_wen, last_mis;
  req_t        exp_req[$];
  done_t       exp_done[$];
  bus_t        bus_q[$];
  done_t       md;
  ysyx_22050243_lsu_if #(.ADDR_W(64), .XLEN(64)) bus ();
  ysyx_22050243_lsu #(.ADDR_W(64), .XLEN(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_r_i   (mem_r),
    .mem_w_i   (mem_w),
    .funct3_i  (funct3),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .stall_o   (stall),
    .done_o    (done),
    .rdata_o   (rdata),
    .misalign_o(misalign),
    .bus       (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic logic [7:0] exp_mask(input bit wen, input logic [2:0] f3, input logic [2:0] off);
    logic [7:0] m = 8'h00;
    if (wen && f3[2]) return 8'h00;
    if (f3[1:0] == 2'd3) return 8'hFF;
    for (int i = 0; i < (1 << f3[1:0]); i++) if (off + i < 8) m[off + i] = 1'b1;
    return m;
  endfunction
  function automatic logic [63:0] exp_load(input logic [2:0] f3, input logic [2:0] off, input logic [63:0] raw);
    int n = 1 << f3[1:0];
    logic [63:0] v = 64'd0;
    if (f3 == 3'b111) return 64'd0;
    for (int i = 0; i < n; i++) if (off + i < 8) v[8*i +: 8] = raw[8*(off + i) +: 8];
    if (!f3[2] && n < 8 && v[8*n - 1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction
  initial begin
    bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.req_ready = 1'b0; bus.resp_valid = 1'b0;
      if (!rst_n) begin ph = 0; bus_q.delete(); end
      else if (force_resp) begin bus.resp_valid = 1'b1; bus.resp_rdata = '1; force_resp = 1'b0; end
      else if (bus_q.size() != 0) begin
        if (ph == 0) begin
          if (bus.req_valid) begin
            if (bus_q[0].rdy == 0) begin bus.req_ready = 1'b1; ph = 1; cnt = bus_q[0].rsp; end
            else bus_q[0].rdy = bus_q[0].rdy - 1;
          end
        end else if (cnt > 1) cnt--;
        else begin
          bus.resp_valid = 1'b1; bus.resp_rdata = bus_q[0].data;
          void'(bus_q.pop_front()); ph = 0;
        end
      end
    end
  end
  always @(negedge clk) if (rst_n) begin
    if (bus.req_valid) begin
      check("req_expected", exp_req.size() != 0, 1);
      if (exp_req.size() != 0) begin
        check("req_addr", bus.req_addr, exp_req[0].addr);
        check("req_wdata", bus.req_wdata, exp_req[0].wdata);
        check("req_wmask", bus.req_wmask, exp_req[0].mask);
        check("req_wen", bus.req_wen, exp_req[0].wen);
        if (bus.req_ready) begin
          last_addr = bus.req_addr; last_wdata = bus.req_wdata; last_wmask = bus.req_wmask; last_wen = bus.req_wen;
          n_req++;
          void'(exp_req.pop_front());
        end
      end
    end
    if (done) begin
      n_done++;
      check("done_expected", exp_done.size() != 0, 1);
      if (exp_done.size() != 0) begin
        md = exp_done.pop_front();
        check("rdata", rdata, md.rdata);
        check("misalign", misalign, md.mis);
        check("latency", cyc - md.issue, md.lat);
        last_rdata = rdata; last_mis = misalign; last_lat = cyc - md.issue;
      end
    end
    check("stall", stall, (mem_r | mem_w) & ~done);
  end
  task automatic access(input bit ld, input bit st, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] rd, input int rdy, input int rsp);
    bit wen = !ld;
    bit mis = 0;
    int k;
    done_t d;
`ifdef YSYX_22050243_LSU_MISALIGN_CHK_EN
    mis = (a % (64'd1 << f3[1:0])) != 0;
`endif
    @(posedge clk); #1;
    mem_r = ld; mem_w = st; funct3 = f3; addr = a; wdata = wd;
    if (!mis) begin
      exp_req.push_back('{a & ~64'h7, wd << (8 * a[2:0]), exp_mask(wen, f3, a[2:0]), wen});
      bus_q.push_back('{rd, rdy, rsp});
    end
    d.rdata = (mis || wen) ? 64'd0 : exp_load(f3, a[2:0], rd);
    d.mis = mis; d.issue = cyc; d.lat = mis ? 1 : 2 + rdy + rsp;
    exp_done.push_back(d);
    for (k = 0; k < 100; k++) begin @(negedge clk); if (done) break; end
    check("done_seen", k < 100, 1);
    if (k == 100) begin exp_req.delete(); exp_done.delete(); bus_q.delete(); end
    @(posedge clk); #1;
    mem_r = 0; mem_w = 0;
  endtask
  task automatic reset_mid(input bit in_wait);
    @(posedge clk); #1;
    mem_r = 1; funct3 = F3_W; addr = 64'h8000_0020; wdata = 0;
    exp_req.push_back('{64'h8000_0020, 64'd0, 8'h0F, 1'b0});
    bus_q.push_back('{64'h1234_5678, in_wait ? 0 : 6, 8});
    @(posedge clk);
    if (in_wait) @(posedge clk);
    @(negedge clk);
    if (!in_wait) check("rst_req_before", bus.req_valid, 1);
    rst_n = 0; mem_r = 0;
    #1;
    check("rst_async_req_valid", bus.req_valid, 0);
    check("rst_async_done", done, 0);
    exp_req.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1; force_resp = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_done", done, 0);
      check("rst_no_req", bus.req_valid, 0);
    end
  endtask
  initial begin
    int nd, nr;
    bit ld, st;
    int mode;
    rst_n = 0; mem_r = 0; mem_w = 0; funct3 = 0; addr = 0; wdata = 0; force_resp = 0;
    repeat (2) @(posedge clk); #1;
    check("rst_req_valid", bus.req_valid, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_misalign", misalign, 0);
    check("rst_wmask", bus.req_wmask, 0);
    check("rst_req_addr", bus.req_addr, 0);
    @(negedge clk); rst_n = 1;
    access(0, 1, F3_H, 64'h8000_0006, 64'h1234, 64'd0, 0, 1);
    check("sh_addr", last_addr, 64'h8000_0000);
    check("sh_wmask", last_wmask, 8'hC0);
    check("sh_wdata", last_wdata, 64'h1234_0000_0000_0000);
    check("sh_wen", last_wen, 1);
    check("sh_lat", last_lat, 3);
    check("sh_rdata", last_rdata, 0);
    access(1, 0, F3_B, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 1);
    check("lb_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    access(1, 0, F3_BU, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 1);
    check("lbu_rdata", last_rdata, 64'h80);
    nd = n_done;
    access(1, 0, F3_W, 64'h8000_0010, 64'd0, 64'h1122_3344_5566_7788, 4, 1);
    check("lw_stall_lat", last_lat, 7);
    check("lw_done_once", n_done - nd, 1);
    check("lw_rdata", last_rdata, 64'h5566_7788);
    nr = n_req;
    access(1, 0, F3_W, 64'h8000_0002, 64'd0, 64'hAABB_CCDD_EEFF_0011, 0, 1);
`ifdef YSYX_22050243_LSU_MISALIGN_CHK_EN
    check("mis_flag", last_mis, 1);
    check("mis_no_req", n_req - nr, 0);
    check("mis_lat", last_lat, 1);
`else
    check("mis_wmask", last_wmask, 8'h3C);
    check("mis_flag", last_mis, 0);
    check("mis_req", n_req - nr, 1);
`endif
    nd = n_done;
    reset_mid(1);
    reset_mid(0);
    check("rst_done_count", n_done - nd, 0);
    access(1, 0, F3_D, 64'h8000_0008, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 1);
    check("post_rst_lat", last_lat, 3);
    check("post_rst_rdata", last_rdata, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 60; i++) begin
      mode = $urandom_range(0, 4);
      ld = mode <= 1 || mode == 4;
      st = mode >= 2;
      access(ld, st, 3'($urandom_range(0, 7)), {32'd0, 32'h8000_0000 | $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(1, 3));
    end
    check("queues_drained", exp_req.size() + exp_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/ysyx_22050243_lsu.md
Name: ysyx_22050243_lsu

Overview:
Multi-cycle load/store unit; the responder for the memory-control outputs of the instruction decoder (`mem_r`, `mem_w`, `funct3`).
- Sits between the execute datapath and the data-memory bus.
- Translates a decoded load/store into a valid/ready bus request with byte-lane alignment.
- Stalls the core until the bus responds, then returns extended load data for write-back.

Parameters:
- ADDR_W, 64, address width (bus address is always 8-byte aligned).
- XLEN, 64, register/data width; bus data width equals XLEN.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_r  in  1  decoded load request.
- mem_w  in  1  decoded store request.
- funct3  in  3  access size/sign, RV64 encoding.
- addr  in  ADDR_W  effective address from ALU.
- wdata  in  XLEN  rs2 store data.
- stall  out  1  core hold; high while access pending.
- done  out  1  one-cycle pulse; access complete.
- rdata  out  XLEN  extended load result, valid when done=1.
- misalign  out  1  misaligned-access flag, valid when done=1.
- req_valid  out  1  bus request valid.
- req_ready  in  1  bus accepts request.
- req_wen  out  1  1 = write.
- req_addr  out  ADDR_W  addr with [2:0] cleared.
- req_wdata  out  XLEN  lane-shifted store data.
- req_wmask  out  8  byte strobes.
- resp_valid  in  1  bus response/ack.
- resp_rdata  in  XLEN  raw 8-byte load data.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state IDLE; all outputs 0; latched operands 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If mem_r|mem_w, latch addr, wdata, funct3 and direction; then go to REQ.
  - mem_r has priority if both are high (illegal; load performed).
  - resp_valid seen in IDLE is discarded.
- REQ:
  - req_valid=1; fields stay stable until req_ready.
  - On req_ready go to WAIT.
  - req_valid never drops before handshake.
- WAIT:
  - On resp_valid, register the extended load result (loads) or the ack (stores); go to DONE.
  - resp_valid arriving in the same cycle as the REQ handshake is not accepted; the bus responds at least one cycle later.
- DONE:
  - done=1 and stall=0 for exactly one cycle; then IDLE.
  - The core advances its PC on done, so the next instruction is sampled in IDLE.
- stall = (mem_r|mem_w) & (state!=DONE).
- Minimum latency: issue cycle to done = 3 cycles with req_ready=1 and resp_valid one cycle after the handshake.
- Lane offset: off = addr[2:0].
- Write mask by funct3:
  - 000 sb: 8'h01<<off.
  - 001 sh: 8'h03<<off.
  - 010 sw: 8'h0F<<off.
  - 011 sd: 8'hFF.
- Store data: req_wdata = wdata << (off*8), truncated to XLEN.
- Load path: shifted = resp_rdata >> (off*8), then extended by funct3:
  - 000 lb: sign-extend from bit 7.
  - 001 lh: sign-extend from bit 15.
  - 010 lw: sign-extend from bit 31.
  - 011 ld: unmodified.
  - 100 lbu, 101 lhu, 110 lwu: zero-extend.
- Reserved encodings:
  - Load funct3=111 and store funct3[2]=1 are performed as 8-byte accesses.
  - Their load result is zero.
  - Store mask for these is 8'h00, i.e. no bytes are written.
- rdata holds its last value until the next load's DONE; it is 0 for stores.
- Reset mid-access: returns to IDLE immediately and req_valid drops asynchronously. A late resp_valid is then ignored.

Optional Feature:
- Macro: YSYX_22050243_LSU_MISALIGN_CHK_EN.
- When defined:
  - Misaligned accesses are detected in IDLE at latch: halfword with off[0]!=0, word with off[1:0]!=0, double with off!=0.
  - A misaligned access skips REQ and WAIT and goes straight to DONE with misalign=1 and rdata=0.
  - No bus transaction occurs.
- When undefined:
  - misalign is tied 0.
  - Misaligned accesses issue with a shifted mask; bytes past lane 7 are silently dropped.

Decomposition:
- Package ysyx_22050243_lsu_pkg holds:
  - the state enum;
  - funct3 constants F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU;
  - the width helper function `size_of(funct3)`.
- One combinational sub-module, ysyx_22050243_lsu_align, holds mask generation, store shift and load shift/extend. The FSM stays in the top.

Test Plan:
- sh, addr=0x8000_0006, wdata=0x1234 -> req_addr=0x8000_0000, req_wmask=0xC0, req_wdata=0x1234_0000_0000_0000, req_wen=1; done 3 cycles after issue; rdata=0.
- lb, addr=0x8000_0003, resp_rdata=0x0000_0000_8000_0000 -> rdata=0xFFFF_FFFF_FFFF_FF80.
- lbu, same stimulus -> rdata=0x80.
- lw, req_ready held low 4 cycles -> req_valid and fields stable throughout; stall=1 throughout; done exactly once, 1 cycle after the resp_valid cycle.
- rst_n pulsed low while in WAIT, then resp_valid=1 after release -> no done; req_valid=0; state IDLE.
- With the macro, lw at addr=0x8000_0002 -> no req_valid; done=1 and misalign=1 on the 2nd cycle. Without the macro -> req_wmask=0x3C and a normal transaction.
